// File: rtl/alu_ctrl_fsm.sv
//------------------------------------------------------------------------------
// alu_ctrl_fsm : four-state sequencer for an external ALU (load A, execute,
//                capture result/flags, report completion with illegal-op flag).
// Optional feature macro: ALU_CTRL_CMP_EN (opcode 101 = CMP, flags-only).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic [31:0] Y,
  input  logic        Z,
  input  logic        N,
  output logic        loadA,
  output logic        add,
  output logic        subtract,
  output logic        bitAnd,
  output logic        bitOr,
  output logic        complement,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic        zflag,
  output logic        nflag,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] C_OP_ADD = 3'b000;
  localparam logic [2:0] C_OP_SUB = 3'b001;
  localparam logic [2:0] C_OP_AND = 3'b010;
  localparam logic [2:0] C_OP_OR  = 3'b011;
  localparam logic [2:0] C_OP_NOT = 3'b100;
`ifdef ALU_CTRL_CMP_EN
  localparam logic [2:0] C_OP_CMP = 3'b101;
`endif

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_op;
  logic [2:0]  w_op_next;
  logic        w_is_cmp;
  logic        w_load_next;
  logic        w_busy_next;
  logic        w_done_next;
  logic        w_err_next;
  logic [4:0]  w_sel_next;
  logic [31:0] w_result_next;
  logic        w_zflag_next;
  logic        w_nflag_next;
  logic [15:0] w_op_count_next;

  // Select vector order: {complement, bitOr, bitAnd, subtract, add}
  function automatic logic [4:0] decode_sel(input logic [2:0] op);
    logic [4:0] s;
    s = 5'b00000;
    case (op)
      C_OP_ADD: s = 5'b00001;
      C_OP_SUB: s = 5'b00010;
      C_OP_AND: s = 5'b00100;
      C_OP_OR:  s = 5'b01000;
      C_OP_NOT: s = 5'b10000;
`ifdef ALU_CTRL_CMP_EN
      C_OP_CMP: s = 5'b00010;
`endif
      default:  s = 5'b00000;
    endcase
    return s;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
`ifdef ALU_CTRL_CMP_EN
    return (op <= 3'd5);
`else
    return (op <= 3'd4);
`endif
  endfunction

`ifdef ALU_CTRL_CMP_EN
  assign w_is_cmp = (r_op == C_OP_CMP);
`else
  assign w_is_cmp = 1'b0;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_op_next       = r_op;
    w_err_next      = 1'b0;
    w_result_next   = result;
    w_zflag_next    = zflag;
    w_nflag_next    = nflag;
    w_op_count_next = op_count;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_op_next    = opcode;
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (op_legal(r_op)) begin
          w_state_next = S_EXEC;
        end else begin
          w_state_next = S_DONE;
          w_err_next   = 1'b1;
        end
      end
      S_EXEC: begin
        // CMP only reports flags; the previous result stays visible.
        if (!w_is_cmp) begin
          w_result_next = Y;
        end
        w_zflag_next    = Z;
        w_nflag_next    = N;
        w_op_count_next = op_count + 16'd1;
        w_state_next    = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          w_op_next    = opcode;
          w_state_next = S_LOAD;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    w_load_next = (w_state_next == S_LOAD);
    w_busy_next = (w_state_next == S_LOAD) || (w_state_next == S_EXEC);
    w_done_next = (w_state_next == S_DONE);
    w_sel_next  = (w_state_next == S_EXEC) ? decode_sel(w_op_next) : 5'b00000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= 3'b000;
      loadA      <= 1'b0;
      add        <= 1'b0;
      subtract   <= 1'b0;
      bitAnd     <= 1'b0;
      bitOr      <= 1'b0;
      complement <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      result     <= 32'd0;
      zflag      <= 1'b0;
      nflag      <= 1'b0;
      op_count   <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_op       <= w_op_next;
      loadA      <= w_load_next;
      add        <= w_sel_next[0];
      subtract   <= w_sel_next[1];
      bitAnd     <= w_sel_next[2];
      bitOr      <= w_sel_next[3];
      complement <= w_sel_next[4];
      busy       <= w_busy_next;
      done       <= w_done_next;
      err        <= w_err_next;
      result     <= w_result_next;
      zflag      <= w_zflag_next;
      nflag      <= w_nflag_next;
      op_count   <= w_op_count_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_fsm.sv
//------------------------------------------------------------------------------
// tb_alu_ctrl_fsm : table-driven bench for alu_ctrl_fsm with a behavioural ALU.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_ctrl_fsm;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic [31:0] alu_y;
  logic        alu_z;
  logic        alu_n;
  logic        loadA, add, subtract, bitAnd, bitOr, complement;
  logic        busy, done, err;
  logic [31:0] result;
  logic        zflag, nflag;
  logic [15:0] op_count;

  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] alu_a;
  logic [4:0]  sel;

  int compared;
  int mismatched;

  alu_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opcode     (opcode),
    .Y          (alu_y),
    .Z          (alu_z),
    .N          (alu_n),
    .loadA      (loadA),
    .add        (add),
    .subtract   (subtract),
    .bitAnd     (bitAnd),
    .bitOr      (bitOr),
    .complement (complement),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .zflag      (zflag),
    .nflag      (nflag),
    .op_count   (op_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: A register loaded on loadA, B driven directly.
  always @(posedge clk) begin
    if (loadA) alu_a <= a_in;
  end

  always_comb begin
    alu_y = 32'd0;
    if (add)             alu_y = b_in + alu_a;
    else if (subtract)   alu_y = b_in - alu_a;
    else if (bitAnd)     alu_y = b_in & alu_a;
    else if (bitOr)      alu_y = b_in | alu_a;
    else if (complement) alu_y = ~alu_a;
  end

  assign alu_z = (alu_y == 32'd0);
  assign alu_n = alu_y[31];
  assign sel   = {complement, bitOr, bitAnd, subtract, add};

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        e;
    logic [4:0]  sel;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_op(input string tag, input vec_t v);
    @(negedge clk);
    start  = 1'b1;
    opcode = v.op;
    a_in   = v.a;
    b_in   = v.b;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_load_pulse"}, 32'(loadA), 32'd1);
    chk({tag, "_load_busy"},  32'(busy),  32'd1);
    chk({tag, "_load_done"},  32'(done),  32'd0);
    @(negedge clk);
    if (v.e) begin
      chk({tag, "_ill_done"}, 32'(done), 32'd1);
      chk({tag, "_ill_err"},  32'(err),  32'd1);
      chk({tag, "_ill_sel"},  32'(sel),  32'd0);
      chk({tag, "_ill_busy"}, 32'(busy), 32'd0);
    end else begin
      chk({tag, "_exec_sel"},  32'(sel),   32'(v.sel));
      chk({tag, "_exec_busy"}, 32'(busy),  32'd1);
      chk({tag, "_exec_load"}, 32'(loadA), 32'd0);
      chk({tag, "_exec_done"}, 32'(done),  32'd0);
      @(negedge clk);
      chk({tag, "_done"},     32'(done), 32'd1);
      chk({tag, "_done_err"}, 32'(err),  32'd0);
      chk({tag, "_done_sel"}, 32'(sel),  32'd0);
    end
    chk({tag, "_result"},   result,         v.res);
    chk({tag, "_zflag"},    32'(zflag),     32'(v.z));
    chk({tag, "_nflag"},    32'(nflag),     32'(v.n));
    chk({tag, "_op_count"}, 32'(op_count),  32'(v.cnt));
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      compared++;
      if (($countones(sel) > 1) || (err && !done) || ((sel != 5'b0) && (!busy || loadA))) begin
        mismatched++;
        $display("FAIL invariant: sel=%b err=%b done=%b busy=%b loadA=%b (t=%0t)",
                 sel, err, done, busy, loadA, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t wv;
    compared   = 0;
    mismatched = 0;
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 3'b000;
    a_in   = 32'd0;
    b_in   = 32'd0;

    vecs[0] = '{3'b000, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0, 5'b00001, 16'd1};
    vecs[1] = '{3'b001, 32'd9,          32'd4,          32'hFFFF_FFFB,  1'b0, 1'b1, 1'b0, 5'b00010, 16'd2};
    vecs[2] = '{3'b100, 32'hFFFF_FFFF,  32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 5'b10000, 16'd3};
    vecs[3] = '{3'b010, 32'hF0F0_F0F0,  32'h3C3C_3C3C,  32'h3030_3030,  1'b0, 1'b0, 1'b0, 5'b00100, 16'd4};
    vecs[4] = '{3'b011, 32'h0000_00FF,  32'h8000_0000,  32'h8000_00FF,  1'b0, 1'b1, 1'b0, 5'b01000, 16'd5};
    vecs[5] = '{3'b000, 32'd2,          32'd3,          32'd5,          1'b0, 1'b0, 1'b0, 5'b00001, 16'd6};
    vecs[6] = '{3'b111, 32'd1,          32'd1,          32'd5,          1'b0, 1'b0, 1'b1, 5'b00000, 16'd6};
    vecs[7] = '{3'b110, 32'd1,          32'd1,          32'd5,          1'b0, 1'b0, 1'b1, 5'b00000, 16'd6};
`ifdef ALU_CTRL_CMP_EN
    vecs[8] = '{3'b101, 32'd3,          32'd3,          32'd5,          1'b1, 1'b0, 1'b0, 5'b00010, 16'd7};
`else
    vecs[8] = '{3'b101, 32'd3,          32'd3,          32'd5,          1'b0, 1'b0, 1'b1, 5'b00000, 16'd6};
`endif

    // Reset values
    @(negedge clk);
    chk("rst_loadA",    32'(loadA),    32'd0);
    chk("rst_sel",      32'(sel),      32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    chk("rst_result",   result,        32'd0);
    chk("rst_flags",    32'({zflag, nflag}), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back: start held for three operations
    @(negedge clk);
    start  = 1'b1;
    opcode = 3'b000;
    a_in   = 32'd1;
    b_in   = 32'd2;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk($sformatf("b2b_done_c%0d", n), 32'(done), ((n % 3 == 0) && (n <= 9)) ? 32'd1 : 32'd0);
      if ((n % 3 == 0) && (n <= 9)) begin
        chk($sformatf("b2b_cnt_c%0d", n), 32'(op_count), 32'(vecs[8].cnt + 16'(n / 3)));
        chk($sformatf("b2b_res_c%0d", n), result, 32'd3);
      end
      if (n >= 10) chk($sformatf("b2b_idle_busy_c%0d", n), 32'(busy), 32'd0);
      if (n == 9) start = 1'b0;
    end

    // Asynchronous reset during EXEC
    @(negedge clk);
    start  = 1'b1;
    opcode = 3'b001;
    a_in   = 32'd1;
    b_in   = 32'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("arst_exec_busy", 32'(busy), 32'd1);
    chk("arst_exec_sel",  32'(sel),  32'b00010);
    #2 reset = 1'b1;
    #1;
    chk("arst_sel",      32'(sel),      32'd0);
    chk("arst_busy",     32'(busy),     32'd0);
    chk("arst_loadA",    32'(loadA),    32'd0);
    chk("arst_done",     32'(done),     32'd0);
    chk("arst_err",      32'(err),      32'd0);
    chk("arst_result",   result,        32'd0);
    chk("arst_flags",    32'({zflag, nflag}), 32'd0);
    chk("arst_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk($sformatf("arst_after_done_c%0d", n), 32'(done), 32'd0);
      chk($sformatf("arst_after_res_c%0d", n),  result,    32'd0);
    end

    // Wrap: preload the counter to 0xFFFF, then one legal op
    @(negedge clk);
    force dut.w_op_count_next = 16'hFFFF;
    @(posedge clk);
    #1 release dut.w_op_count_next;
    @(negedge clk);
    chk("wrap_preset", 32'(op_count), 32'h0000_FFFF);
    wv = '{3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0, 5'b00001, 16'd0};
    run_op("wrap", wv);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
